// File: rtl/booth_ctrl_fsm.sv
// Control FSM for a radix-2 Booth multiplier (IDLE/LOAD/EVAL/SHIFT/DONE).
// Optional macro BOOTH_SKIP_EN: EVAL shifts directly when Q_LSB is 00 or 11.
module booth_ctrl_fsm #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] Q_LSB,
  output logic       load_A,
  output logic       load_B,
  output logic       load_add,
  output logic       add_sub,
  output logic       shift_HQ_LQ_Q_1,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LastIter = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EVAL,
    SHIFT,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  // State and iteration counter; the counter holds N at DONE and never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Outputs decode the registered state (plus Q_LSB in EVAL), so the
  // datapath sees a fresh Q_LSB after every load and shift.
  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    load_A          = 1'b0;
    load_B          = 1'b0;
    load_add        = 1'b0;
    add_sub         = 1'b0;
    shift_HQ_LQ_Q_1 = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end

      LOAD: begin
        load_A  = 1'b1;
        load_B  = 1'b1;
        busy    = 1'b1;
        count_d = '0;
        state_d = EVAL;
      end

      EVAL: begin
        busy    = 1'b1;
        state_d = SHIFT;
        case (Q_LSB)
          2'b01: begin
            load_add = 1'b1;
          end
          2'b10: begin
            load_add = 1'b1;
            add_sub  = 1'b1;
          end
          default: begin
`ifdef BOOTH_SKIP_EN
            shift_HQ_LQ_Q_1 = 1'b1;
            count_d         = count_q + CW'(1);
            state_d         = (count_q == LastIter) ? DONE : EVAL;
`else
            state_d = SHIFT;
`endif
          end
        endcase
      end

      SHIFT: begin
        busy            = 1'b1;
        shift_HQ_LQ_Q_1 = 1'b1;
        count_d         = count_q + CW'(1);
        state_d         = (count_q == LastIter) ? DONE : EVAL;
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_ctrl_fsm.sv
// Self-checking bench for booth_ctrl_fsm with a behavioural Booth datapath.
// Expected latency adapts when compiled with BOOTH_SKIP_EN.
module tb_booth_ctrl_fsm;

  localparam int N = 8;
`ifdef BOOTH_SKIP_EN
  localparam bit SkipEn = 1'b1;
`else
  localparam bit SkipEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, useModel;
  logic [1:0] qLsb, forcedLsb;
  logic loadA, loadB, loadAdd, addSub, shiftOut, busy, done;
  logic [N-1:0] aIn, bIn;

  always #5 clk = ~clk;

  booth_ctrl_fsm #(.N(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .Q_LSB          (qLsb),
    .load_A         (loadA),
    .load_B         (loadB),
    .load_add       (loadAdd),
    .add_sub        (addSub),
    .shift_HQ_LQ_Q_1(shiftOut),
    .busy           (busy),
    .done           (done)
  );

  // Datapath model; HQ carries one guard bit so -2^(N-1) operands do not overflow.
  logic [N-1:0] aM   = '0;
  logic [N-1:0] qM   = '0;
  logic [N:0]   hqM  = '0;
  logic         qm1M = 1'b0;
  logic [2*N-1:0] yM;

  always @(posedge clk) begin
    if (loadA) aM <= aIn;
    if (loadB) begin
      qM   <= bIn;
      hqM  <= '0;
      qm1M <= 1'b0;
    end else if (loadAdd) begin
      hqM <= addSub ? hqM - {aM[N-1], aM} : hqM + {aM[N-1], aM};
    end else if (shiftOut) begin
      {hqM, qM, qm1M} <= {hqM[N], hqM, qM};
    end
  end

  assign yM   = {hqM[N-1:0], qM};
  assign qLsb = useModel ? {qM[0], qm1M} : forcedLsb;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // Continuous exclusivity and single-cycle done monitor.
  logic doneLast = 1'b0;
  always @(negedge clk) begin
    checks++;
    if ((loadAdd === 1'b1 && shiftOut === 1'b1) ||
        ((loadA === 1'b1 || loadB === 1'b1) && (loadAdd === 1'b1 || shiftOut === 1'b1)) ||
        (done === 1'b1 && doneLast === 1'b1)) begin
      errors++;
      $display("[TB] FAIL exclusivity: loadA=%b loadB=%b loadAdd=%b shift=%b done=%b prevDone=%b",
               loadA, loadB, loadAdd, shiftOut, done, doneLast);
    end
    doneLast = done;
  end

  function automatic int countAdds(input logic [N-1:0] b);
    int n;
    logic prev;
    n = 0;
    prev = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (b[i] != prev) n++;
      prev = b[i];
    end
    return n;
  endfunction

  function automatic int expLatency(input logic [N-1:0] b);
    return SkipEn ? (N + 2 + countAdds(b)) : (2 * N + 2);
  endfunction

  // One full multiplication from IDLE; leaves the FSM back in IDLE.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic [2*N-1:0] expY, input string name);
    int cyc, adds, shifts;
    bit seen;
    aIn = a;
    bIn = b;
    useModel = 1'b1;
    start = 1'b1;
    stepClk();
    start = 1'b0;
    cyc = 1;
    adds = 0;
    shifts = 0;
    seen = 1'b0;
    checkOutput({name, " load"}, 32'({loadA, loadB, busy}), 32'd7);
    for (int k = 0; k < 4 * N + 8 && !seen; k++) begin
      stepClk();
      cyc++;
      if (loadAdd) adds++;
      if (shiftOut) shifts++;
      if (done) seen = 1'b1;
    end
    checkOutput({name, " done seen"}, 32'(seen), 32'd1);
    checkOutput({name, " latency"}, 32'(cyc), 32'(expLatency(b)));
    checkOutput({name, " product"}, 32'(yM), 32'(expY));
    checkOutput({name, " adds"}, 32'(adds), 32'(countAdds(b)));
    checkOutput({name, " shifts"}, 32'(shifts), 32'(N));
    checkOutput({name, " busy at done"}, 32'(busy), 32'd0);
    stepClk();
    checkOutput({name, " idle after done"}, 32'({done, busy, loadA}), 32'd0);
  endtask

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] y;
    string          name;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [1:0] pat[4];
    logic [1:0] expAs[4];
    bit seen, skipHere, sawDone;
    int evalCount;

    vecs[0] = '{a: 8'd3,    b: 8'd5,    y: 16'h000F, name: "3x5"};
    vecs[1] = '{a: 8'hF9,  b: 8'd6,    y: 16'hFFD6, name: "-7x6"};
    vecs[2] = '{a: 8'd5,    b: 8'd0,    y: 16'h0000, name: "5x0"};
    vecs[3] = '{a: 8'h7F,  b: 8'hFF,  y: 16'hFF81, name: "127x-1"};
    vecs[4] = '{a: 8'hFF,  b: 8'hFF,  y: 16'h0001, name: "-1x-1"};
    vecs[5] = '{a: 8'h80,  b: 8'h80,  y: 16'h4000, name: "-128x-128"};

    // Reset with start also high: reset must win.
    rst = 1'b1;
    start = 1'b1;
    useModel = 1'b1;
    forcedLsb = 2'b00;
    aIn = '0;
    bIn = '0;
    stepClk();
    stepClk();
    checkOutput("reset outputs", 32'({loadA, loadB, loadAdd, addSub, shiftOut, busy, done}), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    stepClk();
    checkOutput("idle outputs", 32'({loadA, loadB, loadAdd, addSub, shiftOut, busy, done}), 32'd0);

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].a, vecs[v].b, vecs[v].y, vecs[v].name);
    end

    // Forced Q_LSB pattern 10,11,01,00 on the first four EVAL cycles.
    pat[0] = 2'b10; expAs[0] = 2'b11;
    pat[1] = 2'b11; expAs[1] = 2'b00;
    pat[2] = 2'b01; expAs[2] = 2'b10;
    pat[3] = 2'b00; expAs[3] = 2'b00;
    useModel = 1'b0;
    forcedLsb = 2'b00;
    start = 1'b1;
    stepClk();
    start = 1'b0;
    checkOutput("pattern load", 32'({loadA, loadB}), 32'd3);
    stepClk();
    for (int j = 0; j < 4; j++) begin
      forcedLsb = pat[j];
      #1;
      checkOutput($sformatf("pattern eval%0d add/sub", j), 32'({loadAdd, addSub}), 32'(expAs[j]));
      skipHere = SkipEn && (pat[j] == 2'b00 || pat[j] == 2'b11);
      checkOutput($sformatf("pattern eval%0d shift", j), 32'(shiftOut), 32'(skipHere));
      if (!skipHere) begin
        stepClk();
        checkOutput($sformatf("pattern shift%0d", j), 32'({shiftOut, loadAdd}), 32'd2);
      end
      stepClk();
    end
    forcedLsb = 2'b00;
    seen = 1'b0;
    for (int k = 0; k < 4 * N && !seen; k++) begin
      if (done) seen = 1'b1;
      else stepClk();
    end
    checkOutput("pattern done", 32'(seen), 32'd1);
    stepClk();

    // start held high: LOAD, ..., DONE, IDLE gap, LOAD again.
    useModel = 1'b1;
    aIn = 8'd3;
    bIn = 8'd5;
    start = 1'b1;
    stepClk();
    for (int op = 0; op < 3; op++) begin
      checkOutput($sformatf("held load op%0d", op), 32'(loadA), 32'd1);
      seen = 1'b0;
      for (int k = 0; k < 4 * N + 8 && !seen; k++) begin
        stepClk();
        if (done) seen = 1'b1;
      end
      checkOutput($sformatf("held done op%0d", op), 32'(seen), 32'd1);
      checkOutput($sformatf("held product op%0d", op), 32'(yM), 32'h000F);
      stepClk();
      checkOutput($sformatf("held idle gap op%0d", op), 32'({busy, loadA, done}), 32'd0);
      stepClk();
    end
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4 * N + 8 && !seen; k++) begin
      stepClk();
      if (done) seen = 1'b1;
    end
    checkOutput("held final done", 32'(seen), 32'd1);
    stepClk();

    // Abort in the 4th EVAL; every iteration of 0x55 is an add/sub.
    aIn = 8'd3;
    bIn = 8'h55;
    start = 1'b1;
    stepClk();
    start = 1'b0;
    evalCount = 0;
    for (int k = 0; k < 4 * N && evalCount < 4; k++) begin
      stepClk();
      if (loadAdd) evalCount++;
    end
    checkOutput("abort reached eval4", 32'(evalCount), 32'd4);
    rst = 1'b1;
    stepClk();
    rst = 1'b0;
    checkOutput("abort outputs", 32'({loadA, loadB, loadAdd, addSub, shiftOut, busy, done}), 32'd0);
    sawDone = 1'b0;
    for (int k = 0; k < 2 * N + 6; k++) begin
      if (done || busy) sawDone = 1'b1;
      stepClk();
    end
    checkOutput("no activity after abort", 32'(sawDone), 32'd0);
    applyStimulus(8'h80, 8'h80, 16'h4000, "post-abort -128x-128");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
